// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter (CPU / DMAC) with handover only at transfer boundaries.
// Optional hold-limit (bounded wait for the non-owner) enabled by defining ARB_HOLD_LIMIT_EN.
module ahb_bus_arbiter #(
  parameter int unsigned MAX_HOLD     = 16,
  parameter bit          DMA_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CPU_Req,
  input  logic       DMA_Req,
  input  logic [1:0] CPU_HTrans,
  input  logic [1:0] DMA_HTrans,
  input  logic       HReady,
  output logic       CPU_Grant,
  output logic       DMA_Grant,
  output logic       HMaster,
  output logic       HMaster_D
);
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  owner_t     state, state_nxt;
  logic       data_owner;
  logic       cpu_req_q, dma_req_q;
  logic [1:0] owner_trans;
  logic       owner_req, other_req;
  logic       boundary, simul, pri_switch, hold_hit, switch_now;

  always_comb begin
    owner_trans = (state == OWN_DMA) ? DMA_HTrans : CPU_HTrans;
    owner_req   = (state == OWN_DMA) ? DMA_Req : CPU_Req;
    other_req   = (state == OWN_DMA) ? CPU_Req : DMA_Req;
  end

  assign boundary = HReady && (owner_trans != HT_SEQ) && (owner_trans != HT_BUSY);

  // Both masters rising together from an idle bus: priority picks the winner even
  // though the parked owner is now requesting too.
  assign simul      = CPU_Req && DMA_Req && !cpu_req_q && !dma_req_q;
  assign pri_switch = simul && ((state == OWN_CPU) == DMA_PRIORITY);

  assign switch_now = boundary && other_req && (!owner_req || pri_switch || hold_hit);

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic       beat;

  assign beat = HReady && ((owner_trans == HT_NONSEQ) || (owner_trans == HT_SEQ));

  // The beat accepted on this edge counts, so the owner gets exactly MAX_HOLD beats.
  assign hold_hit = other_req &&
                    ((hold_cnt >= HOLD_LIM) || (beat && (hold_cnt == HOLD_LIM - 8'd1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (HReady) begin
      if (switch_now || !other_req) begin
        hold_cnt <= 8'd0;
      end else if (beat && (hold_cnt < HOLD_LIM)) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign hold_hit = 1'b0;

  // MAX_HOLD has no effect when the hold limit is compiled out.
  if (MAX_HOLD == 0) begin : g_max_hold_unused
  end
`endif

  always_comb begin
    state_nxt = state;
    if (switch_now) begin
      state_nxt = (state == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OWN_CPU;
      data_owner <= 1'b0;
      cpu_req_q  <= 1'b0;
      dma_req_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_req_q <= CPU_Req;
      dma_req_q <= DMA_Req;
      if (HReady) begin
        data_owner <= (state == OWN_DMA);
      end
    end
  end

  assign HMaster   = (state == OWN_DMA);
  assign HMaster_D = data_owner;
  assign CPU_Grant = ~HMaster;
  assign DMA_Grant = HMaster;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: vector table for single-edge behaviour plus
// hand-written reset and hold-limit sequences; two instances differ in DMA_PRIORITY.
module tb_ahb_bus_arbiter;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, dma_req = 1'b0, hready = 1'b1;
  logic [1:0] cpu_ht = 2'b00, dma_ht = 2'b00;
  logic       cpu_grant, dma_grant, hmaster, hmaster_d;
  logic       cpu_grant_p0, dma_grant_p0, hmaster_p0, hmaster_d_p0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.MAX_HOLD(4), .DMA_PRIORITY(1'b1)) u_dut (
    .clk(clk), .rst(rst), .CPU_Req(cpu_req), .DMA_Req(dma_req),
    .CPU_HTrans(cpu_ht), .DMA_HTrans(dma_ht), .HReady(hready),
    .CPU_Grant(cpu_grant), .DMA_Grant(dma_grant), .HMaster(hmaster), .HMaster_D(hmaster_d)
  );

  ahb_bus_arbiter #(.MAX_HOLD(4), .DMA_PRIORITY(1'b0)) u_dut_p0 (
    .clk(clk), .rst(rst), .CPU_Req(cpu_req), .DMA_Req(dma_req),
    .CPU_HTrans(cpu_ht), .DMA_HTrans(dma_ht), .HReady(hready),
    .CPU_Grant(cpu_grant_p0), .DMA_Grant(dma_grant_p0), .HMaster(hmaster_p0),
    .HMaster_D(hmaster_d_p0)
  );

  typedef struct {
    logic       cr, dr;
    logic [1:0] ct, dt;
    logic       hr;
    logic       hm, hmd;
    logic       hm0, hmd0;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic hm, input logic hmd,
                           input logic hm0, input logic hmd0);
    check({tag, " hmaster"},      hmaster,      hm);
    check({tag, " hmaster_d"},    hmaster_d,    hmd);
    check({tag, " cpu_grant"},    cpu_grant,    ~hm);
    check({tag, " dma_grant"},    dma_grant,    hm);
    check({tag, " p0 hmaster"},   hmaster_p0,   hm0);
    check({tag, " p0 hmaster_d"}, hmaster_d_p0, hmd0);
    check({tag, " p0 cpu_grant"}, cpu_grant_p0, ~hm0);
    check({tag, " p0 dma_grant"}, dma_grant_p0, hm0);
  endtask

  task automatic drive(input logic cr, input logic dr, input logic [1:0] ct,
                       input logic [1:0] dt, input logic hr);
    cpu_req = cr;
    dma_req = dr;
    cpu_ht  = ct;
    dma_ht  = dt;
    hready  = hr;
  endtask

  initial begin
    //           cr    dr    ct dt hr    hm    hmd   hm0   hmd0
    vecs[0]  = '{1'b0, 1'b0, I, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // idle stays parked
    vecs[1]  = '{1'b0, 1'b1, I, I, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // basic handover
    vecs[2]  = '{1'b0, 1'b1, I, N, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; // DMA first NONSEQ
    vecs[3]  = '{1'b1, 1'b0, I, S, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; // req drops mid-burst
    vecs[4]  = '{1'b1, 1'b0, I, S, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, I, S, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}; // last SEQ
    vecs[6]  = '{1'b1, 1'b0, I, I, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // boundary -> CPU
    vecs[7]  = '{1'b1, 1'b0, N, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, I, I, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // back to DMA
    vecs[9]  = '{1'b1, 1'b0, I, N, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // wait state holds
    vecs[10] = '{1'b1, 1'b0, I, N, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, I, N, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, I, N, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // ready -> CPU
    vecs[13] = '{1'b1, 1'b0, I, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, I, I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // bus idle
    vecs[15] = '{1'b1, 1'b1, I, I, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // simultaneous
    vecs[16] = '{1'b0, 1'b0, I, I, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // no re-park

    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_all("reset released", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].cr, vecs[i].dr, vecs[i].ct, vecs[i].dt, vecs[i].hr);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].hm, vecs[i].hmd, vecs[i].hm0, vecs[i].hmd0);
    end

    // Reset asserted mid-transfer while a wait state is in progress.
    drive(1'b1, 1'b1, I, S, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("reset held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, I, I, 1'b1);
    tick();
    check_all("idle after reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold-limit sequence: DMA takes the bus, then streams NONSEQ beats with CPU waiting.
    drive(1'b0, 1'b1, I, I, 1'b1);
    tick();
    check_all("hold grant dma", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, I, N, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("hold beat%0d", i + 1), (i == 3) ? 1'b0 : 1'b1, 1'b1,
                (i == 3) ? 1'b0 : 1'b1, 1'b1);
    end
    // CPU burst runs past the limit; handover waits for the IDLE boundary.
    for (int i = 0; i < 6; i++) begin
      cpu_ht = (i == 0) ? N : ((i == 5) ? I : S);
      tick();
      check_all($sformatf("hold burst%0d", i), (i == 5) ? 1'b1 : 1'b0, 1'b0,
                (i == 5) ? 1'b1 : 1'b0, 1'b0);
    end
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      check_all($sformatf("nohold beat%0d", i + 1), 1'b1, 1'b1, 1'b1, 1'b1);
    end
    drive(1'b1, 1'b0, I, I, 1'b1);
    tick();
    check_all("nohold release", 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
